// File: rtl/wb_queue_if.sv
// Writeback offer channel: a producer presents {rdsel, data} results to wb_queue.
interface wb_queue_if;
  logic        wb_valid;
  logic [4:0]  wb_rdsel;
  logic [31:0] wb_data;
  logic        wb_ready;

  modport master (output wb_valid, wb_rdsel, wb_data, input wb_ready);
  modport slave  (input wb_valid, wb_rdsel, wb_data, output wb_ready);
endinterface

// File: rtl/wb_queue.sv
// Writeback queue between result producers and the register-file write port,
// with newest-entry forwarding lookup for the two read ports.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_queue_if.slave               wb,
  output logic                    enrd,
  output logic [4:0]              rdsel,
  output logic [31:0]             rd,
  input  logic [4:0]              rs1sel,
  input  logic [4:0]              rs2sel,
  output logic                    fwd1_hit,
  output logic [31:0]             fwd1_data,
  output logic                    fwd2_hit,
  output logic [31:0]             fwd2_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rdsel;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q;
  logic   [AW-1:0]    rd_ptr_q;
  logic   [AW-1:0]    wr_ptr_q;
  logic   [CW-1:0]    count_q;
  logic               push;
  logic               pop;
  entry_t             head;
  entry_t             slot;

  // Ready depends on occupancy alone, so a full queue refuses even while popping.
  assign wb.wb_ready = (count_q < CW'(DEPTH));
  assign pop         = (count_q != '0);
  // Writes to x0 complete the handshake but are dropped here.
  assign push        = wb.wb_valid && wb.wb_ready && (wb.wb_rdsel != 5'd0);

  assign head  = mem_q[rd_ptr_q];
  assign enrd  = pop;
  assign rdsel = head.rdsel;
  assign rd    = head.data;
  assign count = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; slots are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= '{rdsel: wb.wb_rdsel, data: wb.wb_data};
  end

  // Scan oldest to newest so the last match (closest to tail) wins.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        slot = mem_q[rd_ptr_q + AW'(i)];
        if ((rs1sel != 5'd0) && (slot.rdsel == rs1sel)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = slot.data;
        end
        if ((rs2sel != 5'd0) && (slot.rdsel == rs2sel)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = slot.data;
        end
      end
    end
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entry count; power of 2, minimum 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port wb_valid  input  1  producer offers a writeback result this cycle.
REQ-005 SHALL have port wb_rdsel  input  5  destination register index of the offered result.
REQ-006 SHALL have port wb_data  input  32  offered result value.
REQ-007 SHALL have port wb_ready  output  1  queue accepts an offer this cycle.
REQ-008 SHALL have port enrd  output  1  register-file write enable.
REQ-009 SHALL have port rdsel  output  5  register-file write address.
REQ-010 SHALL have port rd  output  32  register-file write data.
REQ-011 SHALL have port rs1sel  input  5  read-port-1 address, for forwarding lookup.
REQ-012 SHALL have port rs2sel  input  5  read-port-2 address, for forwarding lookup.
REQ-013 SHALL have port fwd1_hit  output  1  a pending entry targets rs1sel.
REQ-014 SHALL have port fwd1_data  output  32  newest pending value for rs1sel.
REQ-015 SHALL have port fwd2_hit  output  1  a pending entry targets rs2sel.
REQ-016 SHALL have port fwd2_data  output  32  newest pending value for rs2sel.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL be a FIFO of {rdsel, data} entries with read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL drive wb_ready = (count < DEPTH), a function of registered state only (no dependence on wb_valid).
REQ-020 SHALL complete a handshake on a rising edge where wb_valid && wb_ready.
REQ-021 SHALL enqueue the handshaked entry at the tail, except wb_rdsel == 0: handshake completes, entry discarded, count unchanged.
REQ-022 SHALL drive enrd = (count != 0), rdsel = head rdsel, rd = head data, combinationally from state.
REQ-023 SHALL pop the head on every rising edge where enrd = 1 (write port never stalls).
REQ-024 SHALL give latency: entry handshaked at edge N -> enrd high in cycle N+1 -> register written at edge N+1, when queue empty before N.
REQ-025 SHALL, on simultaneous push and pop, update count by net 0 and preserve FIFO order.
REQ-026 SHALL, when full (count = DEPTH), hold wb_ready low even though a pop occurs that edge; room appears next cycle.
REQ-027 SHALL, when empty, drive enrd = 0; rdsel and rd are don't-care.
REQ-028 SHALL assert fwdN_hit when rsNsel != 0 and any occupied entry (head included) has matching rdsel.
REQ-029 SHALL drive fwdN_data with the data of the newest (closest to tail) matching entry; fwdN_data = 0 when fwdN_hit = 0.
REQ-030 SHALL exclude the offer currently on wb_* (not yet enqueued) from forwarding lookup.
REQ-031 SHALL treat the two forwarding ports independently; both may hit the same entry.

Reset
REQ-032 SHALL, when reset is high at a rising edge, clear pointers and count to 0, discarding all entries.
REQ-033 SHALL ignore any wb handshake occurring at a reset edge (no entry enqueued).
REQ-034 SHALL after reset present enrd = 0, wb_ready = 1, count = 0, fwd1_hit = fwd2_hit = 0, fwd1_data = fwd2_data = 0.
REQ-035 SHALL allow reset mid-operation with the same result as reset from idle; no partial write issued after the reset edge.

Verification
REQ-036 SHALL pass: push {5, 0xDEADBEEF} into empty queue -> next cycle enrd=1, rdsel=5, rd=0xDEADBEEF; following cycle enrd=0, count=0.
REQ-037 SHALL pass: push {0, 0x1234} -> wb_ready stays 1, count stays 0, enrd never asserts.
REQ-038 SHALL pass: hold producer 4 cycles with pop in between -> push {1..4} back-to-back with DEPTH=4: entries drain in order 1,2,3,4 one per cycle, count never exceeds 4; with writes continuously draining, wb_ready never drops.
REQ-039 SHALL pass: queue holds {7,0xA},{9,0xB},{7,0xC}; rs1sel=7, rs2sel=9 -> fwd1_hit=1, fwd1_data=0xC; fwd2_hit=1, fwd2_data=0xB; rs1sel=0 -> fwd1_hit=0.
REQ-040 SHALL pass: fill to DEPTH via forced full state (push each cycle while count=DEPTH) -> wb_ready=0 for the full cycle, offered entry not lost when wb_valid held until ready returns.
REQ-041 SHALL pass: 3 entries queued, reset asserted one cycle with wb_valid=1 -> next cycle count=0, enrd=0, fwd hits 0.
